// File: rtl/axi_interconnect_width_convert_rdata.sv
// Read-data return path of the AXI4 width converter: packs narrow master R beats
// into wide slave R beats under control of the split descriptors, regenerating RLAST.
module axi_interconnect_width_convert_rdata #(
    parameter int WIDTH_ID    = 4,
    parameter int WIDTH_SDATA = 128,
    parameter int WIDTH_MDATA = 32,
    parameter int WIDTH_RUSER = 1,
    parameter int W_ID        = (WIDTH_ID > 0) ? WIDTH_ID : 1,
    parameter int W_RUSER     = (WIDTH_RUSER > 0) ? WIDTH_RUSER : 1,
    parameter int CMD_DEPTH   = 4,
    parameter int U_DLY       = 1
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   split_en,
    input  logic [7:0]             split_len,
    input  logic [7:0]             split_offset,
    input  logic [2:0]             split_size,
    input  logic                   split_tlast,
    output logic                   cmd_full,
    output logic                   err_ovf,
    output logic                   err_len,
    input  logic [W_ID-1:0]        m_rid,
    input  logic [WIDTH_MDATA-1:0] m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rlast,
    input  logic [W_RUSER-1:0]     m_ruser,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic [W_ID-1:0]        s_rid,
    output logic [WIDTH_SDATA-1:0] s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rlast,
    output logic [W_RUSER-1:0]     s_ruser,
    output logic                   s_rvalid,
    input  logic                   s_rready
);

    localparam int MBYTES    = WIDTH_MDATA / 8;
    localparam int MAX_MSIZE = $clog2(MBYTES);
    localparam int LANES     = WIDTH_SDATA / WIDTH_MDATA;
    localparam int LANE_LOG  = $clog2(LANES);
    localparam int LANE_BITS = (LANE_LOG > 0) ? LANE_LOG : 1;
    localparam int PTR_W     = $clog2(CMD_DEPTH);
    localparam bit CFG_OK    = (U_DLY >= 0);

    logic [7:0]           len_mem   [CMD_DEPTH];
    logic [7:0]           offset_mem[CMD_DEPTH];
    logic [2:0]           size_mem  [CMD_DEPTH];
    logic                 tlast_mem [CMD_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       count_next;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    logic                 head_loaded;
    logic [7:0]           beat_cnt;
    logic [7:0]           addr;
    logic [7:0]           head_len;
    logic                 head_tlast;
    logic [2:0]           eff_size;
    logic [LANE_BITS-1:0] lane;
    logic [LANE_BITS-1:0] size_mask;
    logic                 last_beat;
    logic                 group_end;
    logic                 xfer;

    logic [WIDTH_SDATA-1:0] acc_data;
    logic [1:0]             acc_resp;
    logic [WIDTH_SDATA-1:0] merged_data;
    logic [1:0]             merged_resp;

    assign fifo_empty = (count == '0);
    assign head_len   = len_mem[rd_ptr];
    assign head_tlast = tlast_mem[rd_ptr];
    assign last_beat  = (beat_cnt == head_len);

    // Oversized split_size requests are clamped to the number of lane-select bits.
    always_comb begin
        eff_size = size_mem[rd_ptr];
        if (size_mem[rd_ptr] > 3'(LANE_LOG)) begin
            eff_size = 3'(LANE_LOG);
        end
    end

    always_comb begin
        lane      = (LANES > 1) ? addr[MAX_MSIZE +: LANE_BITS] : '0;
        size_mask = ~({LANE_BITS{1'b1}} << eff_size);
        group_end = (((lane + LANE_BITS'(1)) & size_mask) == '0) | last_beat;
    end

    assign m_rready = CFG_OK & head_loaded & (~s_rvalid | s_rready);
    assign xfer     = m_rvalid & m_rready;
    assign pop      = xfer & last_beat;
    assign push     = split_en & (~cmd_full | pop);

    always_comb begin
        count_next = count;
        if (push & ~pop) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (~push & pop) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            len_mem[wr_ptr]    <= split_len;
            offset_mem[wr_ptr] <= split_offset;
            size_mem[wr_ptr]   <= split_size;
            tlast_mem[wr_ptr]  <= split_tlast;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_full <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            cmd_full <= (count_next == (PTR_W+1)'(CMD_DEPTH));
            if (split_en & cmd_full & ~pop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // The head descriptor stays in the FIFO while its beats are counted; a fresh
    // head is picked up on the edge after the previous one is popped.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            head_loaded <= 1'b0;
            beat_cnt    <= '0;
            addr        <= '0;
            err_len     <= 1'b0;
        end else begin
            if (!head_loaded) begin
                if (!fifo_empty) begin
                    head_loaded <= 1'b1;
                    beat_cnt    <= '0;
                    addr        <= offset_mem[rd_ptr];
                end
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 8'd1;
                addr     <= addr + 8'(MBYTES);
                if (last_beat) begin
                    head_loaded <= 1'b0;
                end
            end
            if (xfer && (m_rlast != last_beat)) begin
                err_len <= 1'b1;
            end
        end
    end

    always_comb begin
        merged_data = acc_data;
        merged_data[lane*WIDTH_MDATA +: WIDTH_MDATA] = m_rdata;
        merged_resp = (m_rresp > acc_resp) ? m_rresp : acc_resp;
    end

    // A completing group may refill the output register in the same cycle it is drained.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_resp <= '0;
            s_rdata  <= '0;
            s_rresp  <= '0;
            s_rid    <= '0;
            s_ruser  <= '0;
            s_rlast  <= 1'b0;
            s_rvalid <= 1'b0;
        end else begin
            if (xfer & group_end) begin
                s_rdata  <= merged_data;
                s_rresp  <= merged_resp;
                s_rid    <= m_rid;
                s_ruser  <= m_ruser;
                s_rlast  <= last_beat & head_tlast;
                s_rvalid <= 1'b1;
                acc_data <= '0;
                acc_resp <= '0;
            end else begin
                if (s_rready) begin
                    s_rvalid <= 1'b0;
                end
                if (xfer) begin
                    acc_data <= merged_data;
                    acc_resp <= merged_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_interconnect_width_convert_rdata.sv
// Randomized and directed bench for the R width converter; expected wide beats come
// from a per-descriptor packing model built from the address/lane rules.
module tb_axi_interconnect_width_convert_rdata;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic         split_en;
    logic [7:0]   split_len;
    logic [7:0]   split_offset;
    logic [2:0]   split_size;
    logic         split_tlast;
    logic         cmd_full;
    logic         err_ovf;
    logic         err_len;
    logic [3:0]   m_rid;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic [0:0]   m_ruser;
    logic         m_rvalid;
    logic         m_rready;
    logic [3:0]   s_rid;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic [0:0]   s_ruser;
    logic         s_rvalid;
    logic         s_rready;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [0:0]  user;
        logic        last;
    } narrow_t;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        logic [3:0]   id;
        logic [0:0]   user;
        logic         last;
    } wide_t;

    narrow_t beat_q[$];
    wide_t   exp_q[$];
    int      checks = 0;
    int      failures = 0;
    int      rready_mode = 0;
    bit      gap_en = 0;
    bit      push_done = 0;

    axi_interconnect_width_convert_rdata dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .split_en(split_en), .split_len(split_len), .split_offset(split_offset),
        .split_size(split_size), .split_tlast(split_tlast),
        .cmd_full(cmd_full), .err_ovf(err_ovf), .err_len(err_len),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_ruser(m_ruser), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_ruser(s_ruser), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Slave-side ready pattern, updated just after each rising edge.
    initial begin
        s_rready = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            case (rready_mode)
                0:       s_rready = 1'b1;
                1:       s_rready = ($urandom_range(0, 3) != 0);
                default: s_rready = 1'b0;
            endcase
        end
    end

    // Wide-beat scoreboard plus the backpressure rule on m_rready.
    always @(negedge clk_sys) begin
        if (rst_n && s_rvalid && !s_rready) begin
            checkOutput("bp_mready", {127'd0, m_rready}, 128'd0);
        end
        if (rst_n && s_rvalid && s_rready) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_wide_beat", {127'd0, s_rvalid}, 128'd0);
            end else begin
                checkOutput("s_rdata", s_rdata, exp_q[0].data);
                checkOutput("s_rresp", {126'd0, s_rresp}, {126'd0, exp_q[0].resp});
                checkOutput("s_rid", {124'd0, s_rid}, {124'd0, exp_q[0].id});
                checkOutput("s_ruser", {127'd0, s_ruser}, {127'd0, exp_q[0].user});
                checkOutput("s_rlast", {127'd0, s_rlast}, {127'd0, exp_q[0].last});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyReset();
        rst_n = 1'b0;
        split_en = 1'b0; split_len = '0; split_offset = '0; split_size = '0; split_tlast = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_ruser = '0; m_rlast = 1'b0;
        beat_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
    endtask

    task automatic pushDesc(input int len, input int off, input int size, input bit tlast);
        split_en = 1'b1;
        split_len = 8'(len);
        split_offset = 8'(off);
        split_size = 3'(size);
        split_tlast = tlast;
        @(posedge clk_sys);
        #1 split_en = 1'b0;
    endtask

    // Builds the narrow beats of one descriptor, predicts its wide beats, then pushes it.
    task automatic applyStimulus(input int len, input int off, input int size, input bit tlast,
                                 input bit directed, input int base, input int resp_idx, input int rlast_idx);
        narrow_t      b;
        wide_t        w;
        logic [127:0] acc = '0;
        logic [1:0]   r = '0;
        int           grp = 1 << ((size > 2) ? 2 : size);
        int           a, ln, n;
        for (int i = 0; i <= len; i++) begin
            b.data = directed ? 32'(base + i) : $urandom();
            b.resp = directed ? ((i == resp_idx) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
            b.id   = 4'($urandom_range(0, 15));
            b.user = 1'($urandom_range(0, 1));
            b.last = (rlast_idx >= 0) ? (i == rlast_idx) : (i == len);
            beat_q.push_back(b);
            a  = (off + i * 4) % 256;
            ln = (a / 4) % 4;
            acc[ln*32 +: 32] = b.data;
            if (b.resp > r) r = b.resp;
            if (((ln + 1) % grp) == 0 || i == len) begin
                w.data = acc; w.resp = r; w.id = b.id; w.user = b.user;
                w.last = (i == len) && tlast;
                exp_q.push_back(w);
                acc = '0;
                r = '0;
            end
        end
        n = 0;
        while (cmd_full && n < 500) begin
            @(posedge clk_sys);
            #1 n++;
        end
        if (n >= 500) checkOutput("push_wait", {127'd0, cmd_full}, 128'd0);
        pushDesc(len, off, size, tlast);
    endtask

    task automatic driveOne();
        int n = 0;
        m_rdata = beat_q[0].data; m_rresp = beat_q[0].resp; m_rid = beat_q[0].id;
        m_ruser = beat_q[0].user; m_rlast = beat_q[0].last;
        m_rvalid = 1'b1;
        forever begin
            @(negedge clk_sys);
            if (m_rready) break;
            n++;
            if (n > 500) begin
                checkOutput("drive_timeout", {127'd0, m_rready}, 128'd1);
                beat_q.delete();
                m_rvalid = 1'b0;
                return;
            end
        end
        @(posedge clk_sys);
        #1 m_rvalid = 1'b0;
        void'(beat_q.pop_front());
    endtask

    task automatic driveBeats();
        while (beat_q.size() > 0 || !push_done) begin
            if (beat_q.size() == 0 || (gap_en && $urandom_range(0, 3) == 0)) begin
                @(posedge clk_sys);
                #1;
            end else begin
                driveOne();
            end
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (exp_q.size() == 0 && beat_q.size() == 0) break;
        end
        checkOutput("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int cnt;
        applyReset();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_s_rvalid", {127'd0, s_rvalid}, 128'd0);
        checkOutput("rst_m_rready", {127'd0, m_rready}, 128'd0);
        checkOutput("rst_cmd_full", {127'd0, cmd_full}, 128'd0);
        checkOutput("rst_errs", {126'd0, err_ovf, err_len}, 128'd0);
        checkOutput("rst_s_rdata", s_rdata, 128'd0);
        applyReset();
        push_done = 1;

        $display("[TB] aligned pack");
        applyStimulus(7, 8'h00, 2, 1, 1, 0, -1, -1);
        driveBeats();
        waitDrain();

        $display("[TB] unaligned start");
        applyStimulus(5, 8'h08, 2, 1, 1, 32'hA, -1, -1);
        driveBeats();
        waitDrain();

        $display("[TB] split chain");
        applyStimulus(3, 8'h00, 2, 0, 0, 0, -1, -1);
        applyStimulus(3, 8'h10, 2, 1, 0, 0, -1, -1);
        driveBeats();
        waitDrain();
        checkOutput("chain_err_len", {127'd0, err_len}, 128'd0);

        $display("[TB] backpressure");
        rready_mode = 2;
        applyStimulus(7, 8'h20, 2, 1, 1, 32'h100, -1, -1);
        fork
            driveBeats();
            begin
                cnt = 0;
                while (!s_rvalid && cnt < 200) begin
                    @(negedge clk_sys);
                    cnt++;
                end
                checkOutput("bp_first_valid", {127'd0, s_rvalid}, 128'd1);
                repeat (4) begin
                    @(negedge clk_sys);
                    checkOutput("bp_hold_mready", {127'd0, m_rready}, 128'd0);
                end
                rready_mode = 0;
            end
        join
        waitDrain();

        $display("[TB] response merge");
        applyStimulus(7, 8'h00, 2, 1, 1, 32'h200, 1, -1);
        driveBeats();
        waitDrain();

        $display("[TB] randomized traffic");
        rready_mode = 1;
        gap_en = 1;
        push_done = 0;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    applyStimulus($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 5),
                                  1'($urandom_range(0, 1)), 0, 0, -1, -1);
                end
                push_done = 1;
            end
            driveBeats();
        join
        waitDrain();
        gap_en = 0;
        rready_mode = 0;
        checkOutput("rand_err_ovf", {127'd0, err_ovf}, 128'd0);
        checkOutput("rand_err_len", {127'd0, err_len}, 128'd0);

        $display("[TB] descriptor FIFO full");
        applyReset();
        for (int k = 0; k < 3; k++) applyStimulus(0, k * 4, 0, 1, 1, 32'h300 + k, -1, -1);
        checkOutput("full_after_3", {127'd0, cmd_full}, 128'd0);
        applyStimulus(0, 12, 0, 1, 1, 32'h303, -1, -1);
        checkOutput("full_after_4", {127'd0, cmd_full}, 128'd1);
        checkOutput("ovf_before_drop", {127'd0, err_ovf}, 128'd0);
        pushDesc(0, 16, 0, 1);
        checkOutput("ovf_after_drop", {127'd0, err_ovf}, 128'd1);
        driveBeats();
        waitDrain();
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("no_extra_head", {127'd0, m_rready}, 128'd0);
        checkOutput("full_cleared", {127'd0, cmd_full}, 128'd0);

        $display("[TB] rlast error");
        applyReset();
        applyStimulus(3, 8'h00, 2, 1, 0, 0, -1, 1);
        driveBeats();
        waitDrain();
        checkOutput("err_len_set", {127'd0, err_len}, 128'd1);

        $display("[TB] reset mid-group");
        applyReset();
        rready_mode = 2;
        applyStimulus(7, 8'h00, 2, 1, 1, 32'h400, -1, -1);
        repeat (4) driveOne();
        m_rdata = beat_q[0].data; m_rresp = beat_q[0].resp; m_rid = beat_q[0].id;
        m_ruser = beat_q[0].user; m_rlast = beat_q[0].last;
        m_rvalid = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        checkOutput("pre_reset_valid", {127'd0, s_rvalid}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_s_rvalid", {127'd0, s_rvalid}, 128'd0);
        checkOutput("midrst_m_rready", {127'd0, m_rready}, 128'd0);
        checkOutput("midrst_s_rdata", s_rdata, 128'd0);
        applyReset();
        rready_mode = 0;
        applyStimulus(7, 8'h00, 2, 1, 1, 32'h500, -1, -1);
        driveBeats();
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_interconnect_width_convert_rdata.md
Name: axi_interconnect_width_convert_rdata

Overview:
- Read-data return path of the AXI4 width converter (wide slave port, narrow master port).
- Consumes the per-sub-burst split descriptors (split_en/len/offset/size/tlast) produced by the request-address splitter.
- Packs narrow R beats from the master side into wide R beats for the slave side.
- Regenerates RLAST so the slave sees exactly one burst per original request.

Parameters:
- WIDTH_ID, 4, ID width.
- WIDTH_SDATA, 128, slave-side (wide) data width; power of two, >= WIDTH_MDATA.
- WIDTH_MDATA, 32, master-side (narrow) data width; power of two.
- WIDTH_RUSER, 1, R user width.
- W_ID, (WIDTH_ID>0)?WIDTH_ID:1, physical ID width.
- W_RUSER, (WIDTH_RUSER>0)?WIDTH_RUSER:1, physical user width.
- CMD_DEPTH, 4, split-descriptor FIFO depth; power of two, >= 2.
- U_DLY, 1, register assignment delay.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- split_en  in  1  descriptor push pulse; no ready handshake.
- split_len  in  8  narrow beats minus 1.
- split_offset  in  8  start byte address [7:0].
- split_size  in  3  log2(narrow beats per wide beat).
- split_tlast  in  1  last sub-burst of the original request.
- cmd_full  out  1  descriptor FIFO full.
- err_ovf  out  1  sticky: descriptor dropped on full.
- err_len  out  1  sticky: m_rlast disagrees with beat count.
- m_rid  in  W_ID  narrow R ID.
- m_rdata  in  WIDTH_MDATA  narrow R data.
- m_rresp  in  2  narrow R response.
- m_rlast  in  1  narrow R last.
- m_ruser  in  W_RUSER  narrow R user.
- m_rvalid  in  1  narrow R valid.
- m_rready  out  1  narrow R ready.
- s_rid  out  W_ID  wide R ID.
- s_rdata  out  WIDTH_SDATA  wide R data.
- s_rresp  out  2  wide R response.
- s_rlast  out  1  wide R last.
- s_ruser  out  W_RUSER  wide R user.
- s_rvalid  out  1  wide R valid.
- s_rready  in  1  wide R ready.

Behaviour:
- Clock and reset: single clock clk_sys. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; FIFO empty; beat counter, byte address, accumulator and sticky flags all 0.
- Derived constants:
  - MBYTES = WIDTH_MDATA/8; MAX_MSIZE = clog2(MBYTES).
  - LANES = WIDTH_SDATA/WIDTH_MDATA; LANE_BITS = clog2(LANES), minimum 1.
- Descriptor FIFO:
  - split_en with FIFO not full: push {len, offset, size, tlast}.
  - split_en with FIFO full: drop the descriptor and set err_ovf.
  - cmd_full is registered. Push and pop in the same cycle when full is legal and the push is accepted.
- Descriptor head state: on loading a new head, beat_cnt=0 and addr=split_offset.
- Lane selection: lane = addr[MAX_MSIZE+LANE_BITS-1:MAX_MSIZE]. addr is 8-bit and wraps modulo 256.
- Handshake: m_rready = head_valid & (~s_rvalid | s_rready). Combinational; no dependency on m_rvalid.
- On each narrow transfer (m_rvalid & m_rready):
  - Write m_rdata into accumulator lane `lane`.
  - rresp accumulator = max(acc, m_rresp). Capture m_rid and m_ruser (the last beat wins).
  - addr += MBYTES; beat_cnt += 1.
- Group end when ((lane+1) & ((1<<split_size)-1)) == 0, or when beat_cnt == split_len.
- On group end, in the same edge:
  - Load s_rdata, s_rresp, s_rid and s_ruser from the accumulator merged with the current beat. Lanes not written in the group read as 0.
  - Set s_rvalid=1; s_rlast = (beat_cnt==split_len) & split_tlast.
  - Clear the accumulator and resp accumulator.
- Latency: s_rvalid rises 1 cycle after the group's final narrow transfer. Throughput is one wide beat per cycle with no bubble when s_rready=1.
- s_rvalid clears on s_rvalid & s_rready unless a new group completes in the same cycle, in which case it stays 1 with new data.
- Descriptor completion:
  - When beat_cnt == split_len on a transfer, pop the descriptor.
  - Next head loads on the following edge; back-to-back sub-bursts are allowed.
- Rlast checking: if m_rlast != (beat_cnt==split_len) on a transfer, set err_len. Sticky until reset. Data path is unaffected.
- split_size > LANE_BITS is illegal: clamp to LANE_BITS.
- split_size = 0: every narrow beat is its own wide beat, placed in its address lane.
- Reset mid-burst: everything returns to the reset state immediately; no partial beat is emitted.

Test Plan:
- Aligned pack:
  - Stimulus: SDATA=128, MDATA=32; desc len=7, off=0x00, size=2, tlast=1; m_rdata 0..7.
  - Required: 2 wide beats 0x00000003_00000002_00000001_00000000 and 0x00000007_..._00000004; s_rlast only on the 2nd.
- Unaligned start:
  - Stimulus: off=0x08, len=5, size=2, tlast=1; data A..F.
  - Required: beat 1 = {B, A, 0, 0}; beat 2 = {F, E, D, C} with s_rlast=1.
- Split chain:
  - Stimulus: desc (len=3, tlast=0) then (len=3, tlast=1) pushed back-to-back; 8 narrow beats with m_rlast on beats 4 and 8.
  - Required: 2 wide beats, s_rlast only on the 2nd; err_len=0.
- Backpressure:
  - Stimulus: hold s_rready=0 after the first wide beat completes.
  - Required: m_rready=0 while s_rvalid=1; release gives no loss or duplication; all 8 values correct.
- Response merge:
  - Stimulus: beat 2 of a group has m_rresp=2'b10, others 2'b00.
  - Required: that wide beat has s_rresp=2'b10, the next has 2'b00.
- FIFO full, len error, reset:
  - Stimulus: push 5 descriptors with no R traffic (CMD_DEPTH=4).
  - Required: cmd_full=1 after 4; err_ovf=1.
  - Stimulus: m_rlast on beat 2 of len=3.
  - Required: err_len=1.
  - Stimulus: rst_n low mid-group.
  - Required: s_rvalid=0 and m_rready=0 immediately.
